// File: rtl/countdown_seg7_driver.sv
// rtl/countdown_seg7_driver.sv - three-digit BCD countdown timer with seven-segment outputs
// Optional leading-zero blanking: define COUNTDOWN_LEADING_ZERO_BLANK_EN.
module countdown_seg7_driver #(
  parameter int CLK_HZ        = 25000000,
  parameter int START_SECONDS = 60,
  parameter int BONUS_SECONDS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause_toggle,
  input  logic        add_time,
  output logic [11:0] bcd_value,
  output logic [6:0]  seg7_dig0,
  output logic [6:0]  seg7_dig1,
  output logic [6:0]  seg7_dig2,
  output logic        running,
  output logic        expired,
  output logic        time_up
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  function automatic logic [11:0] to_bcd(input logic [10:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic logic [10:0] to_bin(input logic [11:0] b);
    return 11'(b[11:8]) * 11'd100 + 11'(b[7:4]) * 11'd10 + 11'(b[3:0]);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Packs {hundreds, tens, ones} segment patterns, applying blanking when enabled.
  function automatic logic [20:0] seg_word(input logic [11:0] b);
    logic blank2, blank1;
`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
    blank2 = (b[11:8] == 4'd0);
    blank1 = blank2 && (b[7:4] == 4'd0);
`else
    blank2 = 1'b0;
    blank1 = 1'b0;
`endif
    return {blank2 ? 7'h7F : seg_decode(b[11:8]),
            blank1 ? 7'h7F : seg_decode(b[7:4]),
            seg_decode(b[3:0])};
  endfunction

  localparam logic [11:0] START_BCD = to_bcd(11'(START_SECONDS));
  localparam logic [20:0] START_SEG = seg_word(START_BCD);

  state_t         state, state_n;
  logic [PW-1:0]  psc, psc_n;
  logic [11:0]    bcd_n;
  logic           up_n;
  logic           tick;
  logic [10:0]    sum;

  always_comb begin
    state_n = state;
    bcd_n   = bcd_value;
    psc_n   = psc;
    up_n    = 1'b0;
    tick    = (state == S_RUN) && (psc == PSC_LAST);
    sum     = to_bin(bcd_value);

    if (start) begin
      bcd_n = START_BCD;
      psc_n = '0;
      if (START_SECONDS == 0) begin
        state_n = S_EXPIRED;
        up_n    = 1'b1;
      end else begin
        state_n = S_RUN;
      end
    end else begin
      case (state)
        S_RUN: begin
          psc_n = tick ? '0 : psc + 1'b1;
          if (tick || add_time) begin
            // Binary round trip keeps the combined decrement/bonus a single saturating add.
            sum = to_bin(bcd_value) + (add_time ? 11'(BONUS_SECONDS) : 11'd0)
                  - (tick ? 11'd1 : 11'd0);
            if (sum > 11'd999) sum = 11'd999;
            bcd_n = to_bcd(sum);
          end
          if ((tick || add_time) && sum == 11'd0) begin
            state_n = S_EXPIRED;
            up_n    = 1'b1;
            psc_n   = '0;
          end else if (pause_toggle) begin
            state_n = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (add_time) begin
            sum = to_bin(bcd_value) + 11'(BONUS_SECONDS);
            if (sum > 11'd999) sum = 11'd999;
            bcd_n = to_bcd(sum);
          end
          if (pause_toggle) state_n = S_RUN;
        end
        default: psc_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      psc       <= '0;
      bcd_value <= START_BCD;
      running   <= 1'b0;
      expired   <= 1'b0;
      time_up   <= 1'b0;
      {seg7_dig2, seg7_dig1, seg7_dig0} <= START_SEG;
    end else begin
      state     <= state_n;
      psc       <= psc_n;
      bcd_value <= bcd_n;
      running   <= (state_n == S_RUN);
      expired   <= (state_n == S_EXPIRED);
      time_up   <= up_n;
      // Segments follow the registered value, giving exactly one cycle of lag.
      {seg7_dig2, seg7_dig1, seg7_dig0} <= seg_word(bcd_value);
    end
  end

endmodule

// File: tb/tb_countdown_seg7_driver.sv
// tb/tb_countdown_seg7_driver.sv - directed self-checking bench for countdown_seg7_driver
module tb_countdown_seg7_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [3];
  logic        pause_s [3];
  logic        add_s   [3];
  logic [11:0] bcd     [3];
  logic [6:0]  d0      [3];
  logic [6:0]  d1      [3];
  logic [6:0]  d2      [3];
  logic        run_o   [3];
  logic        exp_o   [3];
  logic        tup_o   [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Instance 0: START=12, instance 1: START=100, instance 2: START=998.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    countdown_seg7_driver #(
      .CLK_HZ(4),
      .START_SECONDS(g == 0 ? 12 : (g == 1 ? 100 : 998)),
      .BONUS_SECONDS(5)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start_s[g]),
      .pause_toggle(pause_s[g]),
      .add_time(add_s[g]),
      .bcd_value(bcd[g]),
      .seg7_dig0(d0[g]),
      .seg7_dig1(d1[g]),
      .seg7_dig2(d2[g]),
      .running(run_o[g]),
      .expired(exp_o[g]),
      .time_up(tup_o[g])
    );
  end

`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = 7'h7F;
`else
  localparam logic [6:0] LEAD_ZERO = 7'h40;
`endif

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] bcd_exp(input int v);
    return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int i, input logic s, input logic p, input logic a);
    start_s[i] = s;
    pause_s[i] = p;
    add_s[i]   = a;
    step(1);
    start_s[i] = 1'b0;
    pause_s[i] = 1'b0;
    add_s[i]   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      pause_s[i] = 1'b0;
      add_s[i]   = 1'b0;
    end
    step(2);
    rst_n = 1'b1;

    // Idle after reset: no counting
    step(10);
    check("idle_bcd", 32'(bcd[0]), 32'h012);
    check("idle_dig2", 32'(d2[0]), 32'(LEAD_ZERO));
    check("idle_dig1", 32'(d1[0]), 32'h79);
    check("idle_dig0", 32'(d0[0]), 32'h24);
    check("idle_running", 32'(run_o[0]), 32'd0);
    check("idle_expired", 32'(exp_o[0]), 32'd0);
    check("idle_time_up", 32'(tup_o[0]), 32'd0);

    // Full countdown 12 -> 0
    pulse(0, 1'b1, 1'b0, 1'b0);
    check("start_bcd", 32'(bcd[0]), 32'h012);
    check("start_running", 32'(run_o[0]), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step(4);
      check($sformatf("cnt_bcd_%0d", k), 32'(bcd[0]), bcd_exp(12 - k));
      check($sformatf("cnt_lag_%0d", k), 32'(d0[0]), 32'(seg_exp((13 - k) % 10)));
      if (k < 12) check($sformatf("cnt_tu_%0d", k), 32'(tup_o[0]), 32'd0);
    end
    check("exp_time_up", 32'(tup_o[0]), 32'd1);
    check("exp_expired", 32'(exp_o[0]), 32'd1);
    check("exp_running", 32'(run_o[0]), 32'd0);
    step(1);
    check("exp_tu_drop", 32'(tup_o[0]), 32'd0);
    check("exp_dig0", 32'(d0[0]), 32'h40);
    check("exp_hold", 32'(exp_o[0]), 32'd1);

    // add_time ignored in EXPIRED
    pulse(0, 1'b0, 1'b0, 1'b1);
    check("exp_add_bcd", 32'(bcd[0]), 32'h000);
    check("exp_add_state", 32'(exp_o[0]), 32'd1);

    // Borrow across two digits: 100 -> 099, then bonus carry 099 -> 104
    pulse(1, 1'b1, 1'b0, 1'b0);
    step(4);
    check("b100_bcd", 32'(bcd[1]), 32'h099);
    step(1);
    check("b100_dig2", 32'(d2[1]), 32'(LEAD_ZERO));
    check("b100_dig1", 32'(d1[1]), 32'h10);
    pulse(1, 1'b0, 1'b0, 1'b1);
    check("b100_add", 32'(bcd[1]), 32'h104);

    // Bonus coincident with tick saturates at 999
    pulse(2, 1'b1, 1'b0, 1'b0);
    step(3);
    check("sat_pre", 32'(bcd[2]), 32'h998);
    pulse(2, 1'b0, 1'b0, 1'b1);
    check("sat_bcd", 32'(bcd[2]), 32'h999);
    check("sat_running", 32'(run_o[2]), 32'd1);

    // Pause with a partially elapsed prescaler, bonus while paused
    pulse(0, 1'b1, 1'b0, 1'b0);
    step(8);
    check("pz_010", 32'(bcd[0]), 32'h010);
    step(2);
    pulse(0, 1'b0, 1'b1, 1'b0);
    check("pz_running", 32'(run_o[0]), 32'd0);
    step(20);
    check("pz_hold", 32'(bcd[0]), 32'h010);
    pulse(0, 1'b0, 1'b0, 1'b1);
    check("pz_add", 32'(bcd[0]), 32'h015);
    pulse(0, 1'b0, 1'b1, 1'b0);
    check("pz_resume", 32'(run_o[0]), 32'd1);
    check("pz_resume_bcd", 32'(bcd[0]), 32'h015);
    step(1);
    check("pz_partial", 32'(bcd[0]), 32'h014);

    // Reset mid-count, then start with simultaneous pause/add
    step(36);
    check("mid_005", 32'(bcd[0]), 32'h005);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("rst_bcd", 32'(bcd[0]), 32'h012);
    check("rst_time_up", 32'(tup_o[0]), 32'd0);
    check("rst_running", 32'(run_o[0]), 32'd0);
    check("rst_dig0", 32'(d0[0]), 32'h24);
    pulse(0, 1'b1, 1'b1, 1'b1);
    check("prio_bcd", 32'(bcd[0]), 32'h012);
    check("prio_running", 32'(run_o[0]), 32'd1);
    step(4);
    check("prio_tick", 32'(bcd[0]), 32'h011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
